keypad_time_entry: RTL and testbench

KEYPAD_TIME_ENTRY -- requirements
Module: keypad_time_entry

---
 rtl/keypad_time_entry.sv | 181 ++++++++++++++++++
 tb/tb_keypad_time_entry.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_time_entry.sv
// Keypad time entry: debounced 12-key input feeding a digit parser that commits HH:MM:SS as packed BCD.
// Optional macro KEYPAD_RANGE_CHECK_EN rejects commits with hour > 23 or minute/second tens > 5.
module keypad_time_entry #(
  parameter int DEB_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [11:0] keypad_in,
  output logic        key_strobe,
  output logic [3:0]  key_code,
  output logic [2:0]  digit_cnt,
  output logic [7:0]  hour_bcd,
  output logic [7:0]  min_bcd,
  output logic [7:0]  sec_bcd,
  output logic        time_valid,
  output logic        entry_err
);

  localparam logic [7:0] DEB = 8'(DEB_CYCLES);

  typedef enum logic [1:0] {IDLE, PEND, FULL} state_t;

  // ---------------- debouncer ----------------
  logic [11:0] vec_reg;
  logic [7:0]  cnt_reg, cnt_next;
  logic        armed_reg, armed_next;
  logic        multi_hot, same, complete, accept;
  logic [3:0]  key_code_reg, key_code_next;
  logic        key_strobe_reg, act_reg;
  logic [3:0]  bit_code [12];

  // Per-key code table, masked by the key's own bit so the OR below yields the one-hot key's code.
  for (genvar gi = 0; gi < 12; gi++) begin : g_code
    localparam logic [3:0] CODE = (gi < 9) ? 4'(gi + 1) : (gi == 9) ? 4'd10 : (gi == 10) ? 4'd0 : 4'd11;
    assign bit_code[gi] = keypad_in[gi] ? CODE : 4'd0;
  end

  always_comb begin
    key_code_next = 4'd0;
    for (int i = 0; i < 12; i++) key_code_next = key_code_next | bit_code[i];
  end

  always_comb begin
    multi_hot = (keypad_in & (keypad_in - 12'd1)) != 12'd0;
    same      = (keypad_in == vec_reg);
    if (multi_hot)          cnt_next = 8'd0;
    else if (!same)         cnt_next = 8'd1;
    else if (cnt_reg == DEB) cnt_next = cnt_reg;
    else                    cnt_next = cnt_reg + 8'd1;
    // Completion fires only on the clock the count first reaches DEB, not while it stays saturated.
    complete   = (cnt_next == DEB) && ((cnt_reg != DEB) || !same);
    accept     = armed_reg && complete && (keypad_in != 12'd0);
    armed_next = complete ? (keypad_in == 12'd0) : armed_reg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec_reg        <= 12'd0;
      cnt_reg        <= 8'd0;
      armed_reg      <= 1'b0;
      key_strobe_reg <= 1'b0;
      key_code_reg   <= 4'd0;
      act_reg        <= 1'b0;
    end else begin
      vec_reg        <= keypad_in;
      cnt_reg        <= cnt_next;
      armed_reg      <= armed_next;
      key_strobe_reg <= accept;
      if (accept) key_code_reg <= key_code_next;
      act_reg        <= accept && en;
    end
  end

  // ---------------- parser ----------------
  state_t     state_reg, state_next;
  logic [3:0] pending_reg;
  logic [3:0] slot_reg [6];
  logic [2:0] digit_cnt_reg;
  logic [7:0] hour_reg, min_reg, sec_reg;
  logic       time_valid_reg, entry_err_reg;
  logic       is_digit, is_star, is_hash;
  logic       load_pend, push, commit, commit_ok, range_ok;

  assign is_digit = key_code_reg <= 4'd9;
  assign is_star  = key_code_reg == 4'd10;
  assign is_hash  = key_code_reg == 4'd11;

`ifdef KEYPAD_RANGE_CHECK_EN
  logic [6:0] hour_val;
  assign hour_val = {3'b000, slot_reg[0]} * 7'd10 + {3'b000, slot_reg[1]};
  assign range_ok = (hour_val <= 7'd23) && (slot_reg[2] <= 4'd5) && (slot_reg[4] <= 4'd5);
`else
  assign range_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (act_reg) begin
      case (state_reg)
        IDLE: if (is_digit) state_next = PEND;
        PEND: begin
          if (is_hash)      state_next = (digit_cnt_reg == 3'd5) ? FULL : IDLE;
          else if (is_star) state_next = IDLE;
        end
        FULL: if (is_star) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    load_pend = 1'b0;
    push      = 1'b0;
    commit    = 1'b0;
    if (act_reg) begin
      case (state_reg)
        IDLE: begin
          load_pend = is_digit;
          commit    = is_star;
        end
        PEND: begin
          load_pend = is_digit;
          push      = is_hash;
          commit    = is_star;
        end
        FULL:    commit = is_star;
        default: ;
      endcase
    end
    commit_ok = commit && (digit_cnt_reg == 3'd6) && range_ok;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_reg    <= 4'd0;
      digit_cnt_reg  <= 3'd0;
      hour_reg       <= 8'h00;
      min_reg        <= 8'h00;
      sec_reg        <= 8'h00;
      time_valid_reg <= 1'b0;
      entry_err_reg  <= 1'b0;
      for (int i = 0; i < 6; i++) slot_reg[i] <= 4'd0;
    end else begin
      time_valid_reg <= commit_ok;
      entry_err_reg  <= commit && !commit_ok;
      if (commit) begin
        pending_reg   <= 4'd0;
        digit_cnt_reg <= 3'd0;
        for (int i = 0; i < 6; i++) slot_reg[i] <= 4'd0;
        if (commit_ok) begin
          hour_reg <= {slot_reg[0], slot_reg[1]};
          min_reg  <= {slot_reg[2], slot_reg[3]};
          sec_reg  <= {slot_reg[4], slot_reg[5]};
        end
      end else begin
        if (load_pend) pending_reg <= key_code_reg;
        if (push) begin
          for (int i = 0; i < 6; i++)
            if (digit_cnt_reg == 3'(i)) slot_reg[i] <= pending_reg;
          digit_cnt_reg <= digit_cnt_reg + 3'd1;
        end
      end
    end
  end

  assign key_strobe = key_strobe_reg;
  assign key_code   = key_code_reg;
  assign digit_cnt  = digit_cnt_reg;
  assign hour_bcd   = hour_reg;
  assign min_bcd    = min_reg;
  assign sec_bcd    = sec_reg;
  assign time_valid = time_valid_reg;
  assign entry_err  = entry_err_reg;

endmodule

// File: tb/tb_keypad_time_entry.sv
// Bench for keypad_time_entry: directed scenarios plus random key sequences checked against a digit-list model.
module tb_keypad_time_entry;
  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        reset, en;
  logic [11:0] keypad_in;
  logic        key_strobe, time_valid, entry_err;
  logic [3:0]  key_code;
  logic [2:0]  digit_cnt;
  logic [7:0]  hour_bcd, min_bcd, sec_bcd;

  keypad_time_entry #(.DEB_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset), .en(en), .keypad_in(keypad_in),
    .key_strobe(key_strobe), .key_code(key_code), .digit_cnt(digit_cnt),
    .hour_bcd(hour_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
    .time_valid(time_valid), .entry_err(entry_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int strobe_cnt = 0, tv_cnt = 0, err_cnt = 0, both_cnt = 0;
  int last_code = -1;

  always @(negedge clk) begin
    if (key_strobe) begin
      strobe_cnt++;
      last_code = int'(key_code);
    end
    if (time_valid) tv_cnt++;
    if (entry_err) err_cnt++;
    if (time_valid && entry_err) both_cnt++;
  end

  // Reference model: confirmed digits as a list, pending digit (-1 = none), expected time and pulse counts.
  int dq[$];
  int pend = -1;
  int exp_h = 0, exp_m = 0, exp_s = 0;
  int exp_tv = 0, exp_err = 0, exp_strobe = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] vec_of(input int code);
    logic [11:0] v;
    v = 12'd0;
    if (code == 0)       v[10] = 1'b1;
    else if (code <= 9)  v[code - 1] = 1'b1;
    else if (code == 10) v[9] = 1'b1;
    else                 v[11] = 1'b1;
    return v;
  endfunction

  task automatic model_key(input int code, input bit en_v);
    bit ok;
    if (!en_v) return;
    if (code <= 9) begin
      if (dq.size() < 6) pend = code;
    end else if (code == 11) begin
      if (pend >= 0) begin
        dq.push_back(pend);
        pend = -1;
      end
    end else begin
      ok = (dq.size() == 6);
`ifdef KEYPAD_RANGE_CHECK_EN
      if (ok) ok = (dq[0] * 10 + dq[1] <= 23) && (dq[2] <= 5) && (dq[4] <= 5);
`endif
      if (ok) begin
        exp_h = dq[0] * 16 + dq[1];
        exp_m = dq[2] * 16 + dq[3];
        exp_s = dq[4] * 16 + dq[5];
        exp_tv++;
      end else begin
        exp_err++;
      end
      dq.delete();
      pend = -1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_strobes"}, strobe_cnt, exp_strobe);
    check({tag, "_digit_cnt"}, int'(digit_cnt), dq.size());
    check({tag, "_time_valid"}, tv_cnt, exp_tv);
    check({tag, "_entry_err"}, err_cnt, exp_err);
    check({tag, "_hour"}, int'(hour_bcd), exp_h);
    check({tag, "_min"}, int'(min_bcd), exp_m);
    check({tag, "_sec"}, int'(sec_bcd), exp_s);
  endtask

  task automatic press(input int code, input bit en_v, input int hold);
    en = en_v;
    keypad_in = vec_of(code);
    repeat (hold) @(negedge clk);
    keypad_in = 12'd0;
    repeat (50) @(negedge clk);
    en = 1'b1;
    exp_strobe++;
    model_key(code, en_v);
    check("key_code", last_code, code);
    check_all("press");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    keypad_in = 12'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    dq.delete();
    pend = -1;
    exp_h = 0; exp_m = 0; exp_s = 0;
    repeat (DEB + 4) @(negedge clk);
  endtask

  int seq1[] = '{1, 11, 0, 11, 2, 11, 3, 11, 4, 11, 5, 11, 10};
  int seq_err[] = '{1, 11, 2, 11, 10};
  int seq_78[] = '{7, 8, 11};
  int seq_rest[] = '{0, 11, 0, 11, 0, 11, 0, 11, 0, 11, 10};
  int seq_new[] = '{2, 11, 1, 11, 3, 11, 0, 11, 5, 11, 9, 11, 10};
`ifdef KEYPAD_RANGE_CHECK_EN
  int seq_ok[] = '{1, 11, 0, 11, 2, 11, 3, 11, 4, 11, 9, 11, 10};
  int seq_bad[] = '{2, 11, 5, 11, 0, 11, 0, 11, 0, 11, 0, 11, 10};
`endif

  initial begin
    int tv0, r, code, s0;
    reset = 1'b1;
    en = 1'b1;
    keypad_in = 12'd0;
    repeat (3) @(negedge clk);
    check("rst_key_strobe", int'(key_strobe), 0);
    check("rst_key_code", int'(key_code), 0);
    check("rst_time_valid", int'(time_valid), 0);
    check("rst_entry_err", int'(entry_err), 0);
    check_all("rst");
    reset = 1'b0;
    repeat (DEB + 4) @(negedge clk);

    tv0 = tv_cnt;
    foreach (seq1[i]) press(seq1[i], 1'b1, 10);
    check("basic_tv_once", tv_cnt - tv0, 1);
    check("basic_hour", int'(hour_bcd), 'h10);
    check("basic_min", int'(min_bcd), 'h23);
    check("basic_sec", int'(sec_bcd), 'h45);

`ifdef KEYPAD_RANGE_CHECK_EN
    foreach (seq_ok[i]) press(seq_ok[i], 1'b1, 10);
    check("range_ok_sec", int'(sec_bcd), 'h49);
    r = err_cnt;
    foreach (seq_bad[i]) press(seq_bad[i], 1'b1, 10);
    check("range_bad_err", err_cnt - r, 1);
    check("range_bad_hour", int'(hour_bcd), 'h10);
`endif

    r = err_cnt;
    foreach (seq_err[i]) press(seq_err[i], 1'b1, 10);
    check("short_err", err_cnt - r, 1);
    check("short_cnt", int'(digit_cnt), 0);
    foreach (seq_78[i]) press(seq_78[i], 1'b1, 10);
    check("overwrite_cnt", int'(digit_cnt), 1);
    foreach (seq_rest[i]) press(seq_rest[i], 1'b1, 10);
`ifndef KEYPAD_RANGE_CHECK_EN
    check("overwrite_hour", int'(hour_bcd), 'h80);
`endif

    // Exactly DEB clocks of stability is accepted.
    press(3, 1'b1, DEB);

    s0 = strobe_cnt;
    keypad_in = vec_of(5);
    repeat (DEB - 1) @(negedge clk);
    keypad_in = 12'd0;
    repeat (20) @(negedge clk);
    check("glitch_no_strobe", strobe_cnt, s0);
    keypad_in = 12'h003;
    repeat (20) @(negedge clk);
    keypad_in = 12'd0;
    repeat (20) @(negedge clk);
    check("multi_no_strobe", strobe_cnt, s0);

    press(4, 1'b1, 10); press(11, 1'b1, 10);
    press(1, 1'b1, 10); press(11, 1'b1, 10);
    press(2, 1'b1, 10); press(11, 1'b1, 10);
    keypad_in = vec_of(7);
    repeat (DEB - 1) @(negedge clk);
    s0 = strobe_cnt;
    do_reset();
    check("reset_no_strobe", strobe_cnt, s0);
    check_all("after_reset");
    tv0 = tv_cnt;
    foreach (seq_new[i]) press(seq_new[i], 1'b1, 10);
    check("reenter_tv_once", tv_cnt - tv0, 1);
    check("reenter_hour", int'(hour_bcd), 'h21);
    check("reenter_sec", int'(sec_bcd), 'h59);

    press(6, 1'b1, 10); press(11, 1'b1, 10);
    press(8, 1'b0, 10); press(11, 1'b0, 10);
    check("en_low_cnt", int'(digit_cnt), 1);

    for (int k = 0; k < 150; k++) begin
      r = int'($urandom_range(0, 19));
      if (r < 10)      code = int'($urandom_range(0, 9));
      else if (r < 17) code = 11;
      else             code = 10;
      press(code, ($urandom_range(0, 9) != 0), int'($urandom_range(DEB, 12)));
    end

    check("never_both", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
